// File: rtl/mcu_rst_req_pkg.sv
// rtl/mcu_rst_req_pkg.sv - shared constants and types for the reset request generator
package mcu_rst_req_pkg;

  localparam logic [9:0] REG_CTRL      = 10'd0;
  localparam logic [9:0] REG_SWRESET   = 10'd1;
  localparam logic [9:0] REG_RESETINFO = 10'd2;
  localparam logic [9:0] REG_STATUS    = 10'd3;

  localparam int INFO_CPU     = 0;
  localparam int INFO_WDOG    = 1;
  localparam int INFO_LOCKUP  = 2;
  localparam int INFO_SW      = 3;
  localparam int INFO_TIMEOUT = 4;
  localparam int INFO_W       = 5;

  localparam logic [15:0] SW_KEY_DEFAULT = 16'h05FA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_WAIT    = 2'b10,
    ST_HOLDOFF = 2'b11
  } rst_state_e;

endpackage

// File: rtl/mcu_rst_req_gen_if.sv
// rtl/mcu_rst_req_gen_if.sv - APB register bus for the reset request generator
interface mcu_rst_req_gen_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/mcu_rst_req_apb_regs.sv
// rtl/mcu_rst_req_apb_regs.sv - APB decode, CTRL, sticky RESETINFO and read mux
module mcu_rst_req_apb_regs
  import mcu_rst_req_pkg::*;
#(
  parameter logic [15:0] SW_KEY = SW_KEY_DEFAULT
) (
  input  logic                clk,
  input  logic                NRST,
  mcu_rst_req_gen_if.slave    apb,
  input  logic                cpu_req,
  input  logic                wdog_req,
  input  logic                lockup,
  input  logic                timeout_set,
  input  rst_state_e          state,
  output logic                sw_req,
  output logic                lockupreset
);

  logic              ctrl_q, ctrl_d;
  logic              sw_req_q, sw_req_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [INFO_W-1:0] info_set, info_clr;
  logic [31:0]       prdata;
  logic              wr;
  logic              unused_pwdata;

  assign wr            = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign unused_pwdata = ^apb.PWDATA[15:5];

  always_comb begin
    ctrl_d   = ctrl_q;
    sw_req_d = 1'b0;
    info_clr = '0;
    info_set = '0;

    if (wr && apb.PADDR == REG_CTRL) begin
      ctrl_d = apb.PWDATA[0];
    end
    // Registered so the request reaches the FSM one cycle after the write.
    if (wr && apb.PADDR == REG_SWRESET && apb.PWDATA[31:16] == SW_KEY && apb.PWDATA[0]) begin
      sw_req_d = 1'b1;
    end
    if (wr && apb.PADDR == REG_RESETINFO) begin
      info_clr = apb.PWDATA[INFO_W-1:0];
    end

    info_set[INFO_CPU]     = cpu_req;
    info_set[INFO_WDOG]    = wdog_req;
    info_set[INFO_LOCKUP]  = lockup & ctrl_q;
    info_set[INFO_SW]      = sw_req_q;
    info_set[INFO_TIMEOUT] = timeout_set;

    // Set after clear so a new event is never lost to a concurrent W1C.
    info_d = (info_q & ~info_clr) | info_set;
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      ctrl_q   <= 1'b0;
      sw_req_q <= 1'b0;
      info_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      sw_req_q <= sw_req_d;
      info_q   <= info_d;
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (apb.PSEL) begin
      case (apb.PADDR)
        REG_CTRL:      prdata = {31'd0, ctrl_q};
        REG_RESETINFO: prdata = {{(32-INFO_W){1'b0}}, info_q};
        REG_STATUS:    prdata = {29'd0, state, (state != ST_IDLE)};
        default:       prdata = 32'd0;
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign sw_req      = sw_req_q;
  assign lockupreset = ctrl_q;

endmodule

// File: rtl/mcu_rst_req_gen.sv
// rtl/mcu_rst_req_gen.sv - stretches reset requests into SYSRESETREQ and waits for HRESETn
module mcu_rst_req_gen
  import mcu_rst_req_pkg::*;
#(
  parameter int          PULSE_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] SW_KEY         = SW_KEY_DEFAULT
) (
  input  logic             clk,
  input  logic             NRST,
  mcu_rst_req_gen_if.slave apb,
  input  logic             CPU_SYSRESETREQ,
  input  logic             WDOG_RESETREQ,
  input  logic             LOCKUP,
  input  logic             HRESETn,
  output logic             SYSRESETREQ,
  output logic             LOCKUPRESET
);

  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             sysresetreq_q, sysresetreq_d;
  logic             sw_req;
  logic             trigger;
  logic             timeout_set;

  assign trigger = CPU_SYSRESETREQ | WDOG_RESETREQ | sw_req;

  mcu_rst_req_apb_regs #(
    .SW_KEY (SW_KEY)
  ) u_regs (
    .clk         (clk),
    .NRST        (NRST),
    .apb         (apb),
    .cpu_req     (CPU_SYSRESETREQ),
    .wdog_req    (WDOG_RESETREQ),
    .lockup      (LOCKUP),
    .timeout_set (timeout_set),
    .state       (state_q),
    .sw_req      (sw_req),
    .lockupreset (LOCKUPRESET)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    // Triggers outside IDLE only reach RESETINFO; the counter is never restarted.
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_ASSERT;
          cnt_d   = PULSE_LOAD;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_WAIT: begin
        if (!HRESETn) begin
          state_d = ST_HOLDOFF;
        end else if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_HOLDOFF: begin
        if (HRESETn) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sysresetreq_d = (state_d == ST_ASSERT) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sysresetreq_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sysresetreq_q <= sysresetreq_d;
    end
  end

  assign SYSRESETREQ = sysresetreq_q;

endmodule
